// File: rtl/slot_scheduler.sv
// Inventory-round sequencer: decodes Query/QueryRep/QueryAdjust, keeps Q, strobes the slot generator.
// Latency: command accepted at edge N, strobe after N, o_reply_en/ARB decision visible after N+3.
// Backpressure: none upstream; commands arriving while busy are dropped and flagged on o_cmd_drop.
module slot_scheduler #(
   parameter logic [3:0] Q_DEFAULT = 4'd4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_cmd_valid,
   input  logic [1:0] i_cmd_type,
   input  logic [3:0] i_q_new,
   input  logic [2:0] i_updn,
   input  logic       i_seed_req,
   input  logic       i_ack_done,
   input  logic       i_slotz_rng,
   output logic [3:0] o_q,
   output logic       o_newSlot,
   output logic       o_decSlot,
   output logic       o_seed_in,
   output logic       o_reply_en,
   output logic       o_busy,
   output logic       o_cmd_drop
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEED   = 3'd1,
      S_DRAW   = 3'd2,
      S_DEC    = 3'd3,
      S_SETTLE = 3'd4,
      S_CHECK  = 3'd5,
      S_ARB    = 3'd6,
      S_REPLY  = 3'd7
   } state_t;

   localparam logic [1:0] CMD_QUERY  = 2'b00;
   localparam logic [1:0] CMD_REP    = 2'b01;
   localparam logic [1:0] CMD_ADJUST = 2'b10;
   localparam logic [1:0] CMD_RSVD   = 2'b11;

   state_t     state_q, state_d;
   logic [3:0] q_q, q_d;
   logic       new_slot_q, new_slot_d;
   logic       dec_slot_q, dec_slot_d;
   logic       seed_in_q, seed_in_d;
   logic       reply_en_q, reply_en_d;
   logic       busy_q, busy_d;
   logic       cmd_drop_q, cmd_drop_d;

   logic       accepting;
   logic       cmd_ok;

   // Next-state, Q update and strobe decode; outputs are registered from the next state.
   always_comb begin
      state_d    = state_q;
      q_d        = q_q;
      new_slot_d = 1'b0;
      dec_slot_d = 1'b0;
      seed_in_d  = 1'b0;
      cmd_drop_d = 1'b0;

      // Reserved command type behaves as if no command arrived at all.
      cmd_ok    = i_cmd_valid && (i_cmd_type != CMD_RSVD);
      accepting = (state_q == S_IDLE) || (state_q == S_ARB) || (state_q == S_REPLY);

      if (accepting) begin
         if (i_seed_req) begin
            state_d    = S_SEED;
            seed_in_d  = 1'b1;
            cmd_drop_d = cmd_ok;
         end else if (cmd_ok && (i_cmd_type == CMD_QUERY)) begin
            q_d        = i_q_new;
            state_d    = S_DRAW;
            new_slot_d = 1'b1;
         end else if (cmd_ok && (i_cmd_type == CMD_ADJUST)) begin
            if ((i_updn == 3'b110) && (q_q != 4'd15)) begin
               q_d = q_q + 4'd1;
            end else if ((i_updn == 3'b011) && (q_q != 4'd0)) begin
               q_d = q_q - 4'd1;
            end
            state_d    = S_DRAW;
            new_slot_d = 1'b1;
         end else if (cmd_ok && (i_cmd_type == CMD_REP) && (state_q != S_IDLE)) begin
            state_d    = S_DEC;
            dec_slot_d = 1'b1;
         end else if (i_ack_done && (state_q == S_REPLY)) begin
            state_d = S_IDLE;
         end
      end else begin
         cmd_drop_d = cmd_ok;
         case (state_q)
            S_SEED:   state_d = S_IDLE;
            S_DRAW:   state_d = S_SETTLE;
            S_DEC:    state_d = S_SETTLE;
            // Generator updates its slot during this cycle; slot-zero is valid next cycle.
            S_SETTLE: state_d = S_CHECK;
            S_CHECK:  state_d = i_slotz_rng ? S_REPLY : S_ARB;
            default:  state_d = S_IDLE;
         endcase
      end

      reply_en_d = (state_d == S_REPLY);
      busy_d     = (state_d == S_SEED) || (state_d == S_DRAW) || (state_d == S_DEC) ||
                   (state_d == S_SETTLE) || (state_d == S_CHECK);
   end

   // State, Q and registered outputs; reset aborts any pass in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         q_q        <= Q_DEFAULT;
         new_slot_q <= 1'b0;
         dec_slot_q <= 1'b0;
         seed_in_q  <= 1'b0;
         reply_en_q <= 1'b0;
         busy_q     <= 1'b0;
         cmd_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         q_q        <= q_d;
         new_slot_q <= new_slot_d;
         dec_slot_q <= dec_slot_d;
         seed_in_q  <= seed_in_d;
         reply_en_q <= reply_en_d;
         busy_q     <= busy_d;
         cmd_drop_q <= cmd_drop_d;
      end
   end

   assign o_q        = q_q;
   assign o_newSlot  = new_slot_q;
   assign o_decSlot  = dec_slot_q;
   assign o_seed_in  = seed_in_q;
   assign o_reply_en = reply_en_q;
   assign o_busy     = busy_q;
   assign o_cmd_drop = cmd_drop_q;

endmodule

// File: tb/tb_slot_scheduler.sv
// Bench for slot_scheduler: directed command sequences against a pass-level model and a slot generator model.
// Outputs checked every falling edge against the model, plus hand-computed literals at key points.
// Inputs are driven 1 time unit after the rising edge.
module tb_slot_scheduler;

   logic       clk;
   logic       rst_n;
   logic       i_cmd_valid;
   logic [1:0] i_cmd_type;
   logic [3:0] i_q_new;
   logic [2:0] i_updn;
   logic       i_seed_req;
   logic       i_ack_done;
   logic       i_slotz_rng;
   logic [3:0] o_q;
   logic       o_newSlot;
   logic       o_decSlot;
   logic       o_seed_in;
   logic       o_reply_en;
   logic       o_busy;
   logic       o_cmd_drop;

   int n_pass  = 0;
   int n_total = 0;

   slot_scheduler #(.Q_DEFAULT(4'd4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_cmd_valid(i_cmd_valid),
      .i_cmd_type (i_cmd_type),
      .i_q_new    (i_q_new),
      .i_updn     (i_updn),
      .i_seed_req (i_seed_req),
      .i_ack_done (i_ack_done),
      .i_slotz_rng(i_slotz_rng),
      .o_q        (o_q),
      .o_newSlot  (o_newSlot),
      .o_decSlot  (o_decSlot),
      .o_seed_in  (o_seed_in),
      .o_reply_en (o_reply_en),
      .o_busy     (o_busy),
      .o_cmd_drop (o_cmd_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slot generator stand-in: loads a chosen value on new-slot, decrements (15-bit wrap) on dec-slot.
   logic [14:0] slot;
   logic [14:0] rnd_val;
   logic [15:0] mask16;
   initial slot = 15'd0;
   always @(posedge clk) begin
      if (o_newSlot)      slot <= rnd_val;
      else if (o_decSlot) slot <= slot - 15'd1;
   end
   assign mask16      = (16'd1 << o_q) - 16'd1;
   assign i_slotz_rng = ((slot & mask16[14:0]) == 15'd0);

   // Pass-level model: a command occupies a fixed number of busy cycles, then resolves to a mode.
   localparam int M_IDLE = 0, M_ARB = 1, M_REPLY = 2;
   int   m_mode;
   int   pass_left;
   bit   pass_is_seed;
   int   m_q;
   bit   e_new, e_dec, e_seed, e_drop, e_busy, e_reply;
   bit   cmd_ok;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_IDLE; pass_left = 0; pass_is_seed = 0; m_q = 4;
         e_new = 0; e_dec = 0; e_seed = 0; e_drop = 0; e_busy = 0; e_reply = 0;
      end else begin
         e_new = 0; e_dec = 0; e_seed = 0; e_drop = 0;
         cmd_ok = i_cmd_valid && (i_cmd_type != 2'b11);
         if (pass_left > 0) begin
            e_drop = cmd_ok;
            pass_left = pass_left - 1;
            if (pass_left == 0)
               m_mode = pass_is_seed ? M_IDLE : (i_slotz_rng ? M_REPLY : M_ARB);
         end else if (i_seed_req) begin
            e_seed = 1; e_drop = cmd_ok; pass_left = 1; pass_is_seed = 1;
         end else if (cmd_ok && i_cmd_type == 2'b00) begin
            m_q = int'(i_q_new); e_new = 1; pass_left = 3; pass_is_seed = 0;
         end else if (cmd_ok && i_cmd_type == 2'b10) begin
            if (i_updn == 3'b110) m_q = (m_q == 15) ? 15 : m_q + 1;
            else if (i_updn == 3'b011) m_q = (m_q == 0) ? 0 : m_q - 1;
            e_new = 1; pass_left = 3; pass_is_seed = 0;
         end else if (cmd_ok && i_cmd_type == 2'b01 && m_mode != M_IDLE) begin
            e_dec = 1; pass_left = 3; pass_is_seed = 0;
         end else if (i_ack_done && m_mode == M_REPLY) begin
            m_mode = M_IDLE;
         end
         e_busy  = (pass_left > 0);
         e_reply = !e_busy && (m_mode == M_REPLY);
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [9:0] act, exp_v;
      act   = {o_q, o_newSlot, o_decSlot, o_seed_in, o_reply_en, o_busy, o_cmd_drop};
      exp_v = {4'(m_q), e_new, e_dec, e_seed, e_reply, e_busy, e_drop};
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL model_cmp t=%0t actual q/new/dec/seed/rep/busy/drop=%b required=%b",
                    $time, act, exp_v);
   end

   task automatic chk(input string nm, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Present one command for one sampling edge; returns just after that edge.
   task automatic send(input logic [1:0] t, input logic [3:0] q, input logic [2:0] ud);
      i_cmd_valid = 1'b1; i_cmd_type = t; i_q_new = q; i_updn = ud;
      step();
      i_cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_type = 2'b00; i_q_new = 4'd0; i_updn = 3'd0;
      i_seed_req = 1'b0; i_ack_done = 1'b0; rnd_val = 15'd0;
      steps(2);
      chk("reset_q", int'(o_q), 4);
      chk("reset_busy", int'(o_busy), 0);
      chk("reset_strobes", int'({o_newSlot, o_decSlot, o_seed_in, o_reply_en, o_cmd_drop}), 0);
      rst_n = 1'b1;
      step();

      // QueryRep in IDLE is ignored without a drop flag.
      send(2'b01, 4'd0, 3'd0);
      chk("rep_idle_dec", int'(o_decSlot), 0);
      chk("rep_idle_drop", int'(o_cmd_drop), 0);

      // Q=0: empty mask, replies straight away; reply_en after the 4th edge from issue.
      rnd_val = 15'd5;
      send(2'b00, 4'd0, 3'd0);
      chk("q0_newslot", int'(o_newSlot), 1);
      steps(2);
      chk("q0_reply_early", int'(o_reply_en), 0);
      step();
      chk("q0_reply", int'(o_reply_en), 1);
      i_ack_done = 1'b1; step(); i_ack_done = 1'b0;
      chk("ack_leave", int'(o_reply_en), 0);

      // Q=2, slot 3 -> ARB; three QueryReps count 2,1,0 -> REPLY on the third.
      rnd_val = 15'd3;
      send(2'b00, 4'd2, 3'd0);
      steps(3);
      chk("q2_arb", int'(o_reply_en), 0);
      i_ack_done = 1'b1; step(); i_ack_done = 1'b0;
      send(2'b11, 4'd9, 3'd0);
      chk("rsvd_nodrop", int'(o_cmd_drop), 0);
      for (int k = 0; k < 3; k++) begin
         send(2'b01, 4'd0, 3'd0);
         chk("rep_decslot", int'(o_decSlot), 1);
         steps(3);
         chk("rep_reply", int'(o_reply_en), (k == 2) ? 1 : 0);
      end
      i_ack_done = 1'b1; step(); i_ack_done = 1'b0;

      // Saturation at both ends of Q, each adjust triggers a fresh draw.
      rnd_val = 15'd0;
      send(2'b00, 4'd15, 3'd0);
      steps(3);
      chk("q15_reply", int'(o_reply_en), 1);
      rnd_val = 15'd1;
      send(2'b10, 4'd0, 3'b110);
      chk("adj_up_sat", int'(o_q), 15);
      chk("adj_up_newslot", int'(o_newSlot), 1);
      steps(3);
      chk("adj_up_arb", int'(o_reply_en), 0);
      rnd_val = 15'd9;
      send(2'b00, 4'd0, 3'd0);
      steps(3);
      send(2'b10, 4'd0, 3'b011);
      chk("adj_dn_sat", int'(o_q), 0);
      chk("adj_dn_newslot", int'(o_newSlot), 1);
      steps(3);
      chk("adj_dn_reply", int'(o_reply_en), 1);
      i_ack_done = 1'b1; step(); i_ack_done = 1'b0;

      // Query during SETTLE is dropped; seed plus Query in IDLE takes the seed and drops the Query.
      rnd_val = 15'd2;
      send(2'b00, 4'd1, 3'd0);
      step();
      send(2'b00, 4'd9, 3'd0);
      chk("busy_drop", int'(o_cmd_drop), 1);
      chk("busy_q_kept", int'(o_q), 1);
      step();
      chk("busy_q1_reply", int'(o_reply_en), 1);
      i_ack_done = 1'b1; step(); i_ack_done = 1'b0;
      i_seed_req = 1'b1;
      send(2'b00, 4'd7, 3'd0);
      i_seed_req = 1'b0;
      chk("seed_in", int'(o_seed_in), 1);
      chk("seed_drop", int'(o_cmd_drop), 1);
      chk("seed_q_kept", int'(o_q), 1);
      step();
      chk("seed_done", int'(o_busy), 0);

      // REPLY at Q=3, QueryRep wraps slot to 7FFF (masked 7) -> ARB.
      rnd_val = 15'd0;
      send(2'b00, 4'd3, 3'd0);
      steps(3);
      chk("q3_reply", int'(o_reply_en), 1);
      send(2'b01, 4'd0, 3'd0);
      steps(3);
      chk("wrap_arb", int'(o_reply_en), 0);

      // Reset during DRAW aborts the pass.
      send(2'b00, 4'd5, 3'd0);
      chk("draw_busy", int'(o_busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(o_busy), 0);
      chk("midrst_q", int'(o_q), 4);
      chk("midrst_newslot", int'(o_newSlot), 0);
      step();
      rst_n = 1'b1;
      steps(2);
      chk("postrst_idle", int'({o_busy, o_reply_en}), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
